// File: rtl/credit_control_multi_channel_if.sv
// Command request/grant and PSL response bus between the engine arbiters and the credit controller.
interface credit_control_multi_channel_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned RESP_W = 9
) ();
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] request;
    logic [NUM_CH-1:0] grant;
    logic              valid_response;
    logic [CH_W-1:0]   response_ch;
    logic [RESP_W-1:0] response_credits;

    modport master (
        output request,
        output valid_response,
        output response_ch,
        output response_credits,
        input  grant
    );

    modport slave (
        input  request,
        input  valid_response,
        input  response_ch,
        input  response_credits,
        output grant
    );
endinterface

// File: rtl/credit_control_multi_channel.sv
// Shared-pool CAPI command-credit controller: round-robin grants, PSL credit returns, per-channel counts.
// Optional build macro CREDIT_CHECK_EN adds the sticky credit_error checker.
module credit_control_multi_channel #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned RESP_W   = 9,
    parameter int unsigned OUTS_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_room,
    input  logic [CREDIT_W-1:0]        room,
    credit_control_multi_channel_if.slave bus,
    output logic [CREDIT_W-1:0]        credits,
    output logic [NUM_CH*OUTS_W-1:0]   outstanding,
    output logic                       credit_error
);
    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SUM_W = CREDIT_W + 2;
    localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

    logic [CREDIT_W-1:0]     room_reg;
    logic [CH_W-1:0]         rr_ptr;
    logic [OUTS_W-1:0]       outs_q    [NUM_CH];
    logic [OUTS_W-1:0]       outs_next [NUM_CH];

    logic [NUM_CH-1:0]       grant_vec;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_any;
    logic [CH_W-1:0]         rr_next;

    logic signed [SUM_W-1:0] resp_ext;
    logic signed [SUM_W-1:0] room_ext;
    logic signed [SUM_W-1:0] pool_sum;
    logic [CREDIT_W-1:0]     pool_next;

    // Round-robin search starting at rr_ptr; only while the pool holds credits.
    always_comb begin
        int unsigned k;
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        k         = 0;
        if (credits != '0) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                k = (32'(rr_ptr) + i) % NUM_CH;
                if (!grant_any && bus.request[CH_W'(k)]) begin
                    grant_any             = 1'b1;
                    grant_idx             = CH_W'(k);
                    grant_vec[CH_W'(k)]   = 1'b1;
                end
            end
        end
    end

    assign bus.grant = grant_vec;
    assign rr_next   = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

    // Unclamped pool arithmetic carries two guard bits so both under- and overflow are visible.
    assign resp_ext = SUM_W'($signed(bus.response_credits));
    assign room_ext = $signed({2'b00, room_reg});
    assign pool_sum = $signed({2'b00, credits}) - SUM_W'(grant_any)
                    + (bus.valid_response ? resp_ext : '0);

    always_comb begin
        pool_next = CREDIT_W'(pool_sum);
        if (pool_sum[SUM_W-1]) begin
            pool_next = '0;
        end else if (pool_sum > room_ext) begin
            pool_next = room_reg;
        end
    end

    // Grant and response to the same channel cancel; otherwise step and saturate.
    always_comb begin
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            outs_next[ch] = outs_q[ch];
            if (grant_vec[ch] &&
                !(bus.valid_response && bus.response_ch == CH_W'(ch))) begin
                if (outs_q[ch] != OUTS_MAX) begin
                    outs_next[ch] = outs_q[ch] + OUTS_W'(1);
                end
            end else if (!grant_vec[ch] &&
                         bus.valid_response && bus.response_ch == CH_W'(ch)) begin
                if (outs_q[ch] != '0) begin
                    outs_next[ch] = outs_q[ch] - OUTS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credits  <= '0;
            room_reg <= '0;
            rr_ptr   <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                outs_q[ch] <= '0;
            end
        end else if (load_room) begin
            credits  <= room;
            room_reg <= room;
            rr_ptr   <= '0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                outs_q[ch] <= '0;
            end
        end else begin
            credits <= pool_next;
            if (grant_any) begin
                rr_ptr <= rr_next;
            end
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                outs_q[ch] <= outs_next[ch];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_outs
        assign outstanding[g*OUTS_W +: OUTS_W] = outs_q[g];
    end

`ifdef CREDIT_CHECK_EN
    logic resp_outs_zero;
    logic resp_out_of_range;
    logic err_c;

    always_comb begin
        resp_outs_zero = 1'b0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (bus.response_ch == CH_W'(ch) && outs_q[ch] == '0) begin
                resp_outs_zero = 1'b1;
            end
        end
    end

    assign resp_out_of_range = (32'(bus.response_ch) >= NUM_CH);
    assign err_c = pool_sum[SUM_W-1] || (pool_sum > room_ext) ||
                   (bus.valid_response && (resp_out_of_range || resp_outs_zero));

    // Sticky until the pool is reset or reloaded.
    always_ff @(posedge clock) begin
        if (reset || load_room) begin
            credit_error <= 1'b0;
        end else if (err_c) begin
            credit_error <= 1'b1;
        end
    end
`else
    assign credit_error = 1'b0;
`endif

endmodule
